// File: rtl/eth_frame_loop_tx_if.sv
// eth_frame_loop_tx_if: one AXI-Stream channel (data, last, valid, ready).
// The same bundle carries the frame bytes, the 48-bit control words and the
// MAC-side output; W sets the data width of each instance.
interface eth_frame_loop_tx_if #(
  parameter int W = 8
);
  logic [W-1:0] tdata;
  logic         tlast;
  logic         tvalid;
  logic         tready;

  modport master (output tdata, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/eth_frame_loop_tx.sv
// eth_frame_loop_tx: TX-domain consumer of the loop FIFO.
// Takes one control word per frame, then forwards or discards that frame.
// Forwarded frames have their L4 and IPv4 checksum bytes patched in flight.
// Runts are zero-padded up to C_MIN_FRAME_SIZE. The MAC appends the FCS.
module eth_frame_loop_tx #(
  parameter int C_MIN_FRAME_SIZE  = 60,
  parameter bit C_FORWARD_BAD_FCS = 1'b0,
  parameter int C_IP_CSUM_OFFSET  = 24
) (
  input  logic                       clk,
  input  logic                       rst_n,
  eth_frame_loop_tx_if.slave         s_axis_frame,
  eth_frame_loop_tx_if.slave         s_axis_ctl,
  eth_frame_loop_tx_if.master        m_axis,
  output logic [31:0]                frames_sent,
  output logic [31:0]                frames_dropped
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_FORWARD = 2'd1;
  localparam logic [1:0] ST_PAD     = 2'd2;
  localparam logic [1:0] ST_DISCARD = 2'd3;

  localparam logic [15:0] MIN_LAST = 16'(C_MIN_FRAME_SIZE - 1);
  localparam logic [15:0] IP_HI    = 16'(C_IP_CSUM_OFFSET);
  localparam logic [15:0] IP_LO    = 16'(C_IP_CSUM_OFFSET + 1);

  logic [1:0]  state;
  logic [15:0] idx;
  logic [15:0] idx_inc;
  logic [15:0] ip_csum_q;
  logic [15:0] csum_val_q;
  logic [13:0] csum_pos_q;
  logic [15:0] pos_hi;
  logic [15:0] pos_lo;
  logic        run_q;
  logic        ctl_fire;
  logic        out_fire;
  logic        discard;
  logic [7:0]  base_byte;
  logic [7:0]  out_byte;

  // Handshake qualifiers and the per-frame decision taken from the incoming control word.
  // run_q keeps ctl tready low for the first cycle after reset so every ready output reads 0 in reset.
  always_comb begin
    ctl_fire = (state == ST_IDLE) && run_q && s_axis_ctl.tvalid;
    out_fire = m_axis.tvalid && m_axis.tready;
    discard  = s_axis_ctl.tdata[1] || (s_axis_ctl.tdata[0] && !C_FORWARD_BAD_FCS);
    idx_inc  = (idx == 16'hFFFF) ? idx : idx + 16'd1;
    pos_hi   = {2'b00, csum_pos_q};
    pos_lo   = {2'b00, csum_pos_q} + 16'd1;
  end

  // Checksum substitution by byte position; L4 checksum wins over the IP checksum on overlap.
  // Padding bytes go through the same path so patch offsets inside the pad still get written.
  always_comb begin
    base_byte = (state == ST_FORWARD) ? s_axis_frame.tdata : 8'h00;
    out_byte  = base_byte;
    if (csum_pos_q != 14'd0) begin
      if (idx == pos_hi) begin
        out_byte = csum_val_q[15:8];
      end else if (idx == pos_lo) begin
        out_byte = csum_val_q[7:0];
      end else if (idx == IP_HI) begin
        out_byte = ip_csum_q[15:8];
      end else if (idx == IP_LO) begin
        out_byte = ip_csum_q[7:0];
      end
    end
  end

  // Output and ready steering per state; forwarding is a zero-latency pass-through.
  always_comb begin
    s_axis_ctl.tready   = (state == ST_IDLE) && run_q;
    s_axis_frame.tready = 1'b0;
    m_axis.tvalid       = 1'b0;
    m_axis.tlast        = 1'b0;
    m_axis.tdata        = 8'h00;
    case (state)
      ST_FORWARD: begin
        s_axis_frame.tready = m_axis.tready;
        m_axis.tvalid       = s_axis_frame.tvalid;
        m_axis.tlast        = s_axis_frame.tlast && (idx >= MIN_LAST);
        m_axis.tdata        = out_byte;
      end
      ST_PAD: begin
        m_axis.tvalid = 1'b1;
        m_axis.tlast  = (idx == MIN_LAST);
        m_axis.tdata  = out_byte;
      end
      ST_DISCARD: begin
        s_axis_frame.tready = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Frame FSM, byte counter, latched control fields and the frame counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      idx            <= 16'd0;
      ip_csum_q      <= 16'd0;
      csum_val_q     <= 16'd0;
      csum_pos_q     <= 14'd0;
      run_q          <= 1'b0;
      frames_sent    <= 32'd0;
      frames_dropped <= 32'd0;
    end else begin
      run_q <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (ctl_fire) begin
            ip_csum_q  <= s_axis_ctl.tdata[47:32];
            csum_val_q <= s_axis_ctl.tdata[31:16];
            csum_pos_q <= s_axis_ctl.tdata[15:2];
            idx        <= 16'd0;
            state      <= discard ? ST_DISCARD : ST_FORWARD;
          end
        end
        ST_FORWARD: begin
          if (out_fire) begin
            idx <= idx_inc;
            if (s_axis_frame.tlast) begin
              if (idx >= MIN_LAST) begin
                frames_sent <= frames_sent + 32'd1;
                state       <= ST_IDLE;
              end else begin
                state <= ST_PAD;
              end
            end
          end
        end
        ST_PAD: begin
          if (out_fire) begin
            idx <= idx_inc;
            if (idx == MIN_LAST) begin
              frames_sent <= frames_sent + 32'd1;
              state       <= ST_IDLE;
            end
          end
        end
        ST_DISCARD: begin
          if (s_axis_frame.tvalid && s_axis_frame.tlast) begin
            frames_dropped <= frames_dropped + 32'd1;
            state          <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_frame_loop_tx.sv
// tb_eth_frame_loop_tx: scoreboard bench for eth_frame_loop_tx.
// Stimulus pushes the expected output bytes into a queue; a monitor pops and
// compares every byte the DUT hands to the MAC. A second instance forwards bad-FCS frames.
module tb_eth_frame_loop_tx;

  logic clk = 1'b0;
  logic rst_n;
  logic [31:0] frames_sent, frames_dropped;
  logic [31:0] fwd_sent, fwd_dropped;

  int errors = 0;
  int checks = 0;
  bit rand_ready = 1'b0;

  logic [8:0] exp_q[$];
  logic [8:0] exp_word;
  logic [7:0] cap [0:255];
  int         pos = 0;
  bit         stalled = 1'b0;
  logic [8:0] st_word;
  int         f_cnt = 0;
  int         f_last = -1;
  logic [7:0] f_b0 = 8'h00;

  eth_frame_loop_tx_if #(.W(8))  frame_if ();
  eth_frame_loop_tx_if #(.W(48)) ctl_if ();
  eth_frame_loop_tx_if #(.W(8))  m_if ();
  eth_frame_loop_tx_if #(.W(8))  f_frame ();
  eth_frame_loop_tx_if #(.W(48)) f_ctl ();
  eth_frame_loop_tx_if #(.W(8))  f_m ();

  eth_frame_loop_tx u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .s_axis_frame   (frame_if.slave),
    .s_axis_ctl     (ctl_if.slave),
    .m_axis         (m_if.master),
    .frames_sent    (frames_sent),
    .frames_dropped (frames_dropped)
  );

  eth_frame_loop_tx #(.C_FORWARD_BAD_FCS(1'b1)) u_dut_fwd (
    .clk            (clk),
    .rst_n          (rst_n),
    .s_axis_frame   (f_frame.slave),
    .s_axis_ctl     (f_ctl.slave),
    .m_axis         (f_m.master),
    .frames_sent    (fwd_sent),
    .frames_dropped (fwd_dropped)
  );

  always #5 clk = ~clk;

  // Global watchdog so a wedged DUT can never hang the run.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [7:0] din(input int i, input int seed);
    return 8'((i * 13 + seed) & 255);
  endfunction

  // Reference checksum patching: L4 pair first, then IP pair, only when CSUM_POS is non-zero.
  function automatic logic [7:0] expByte(input logic [47:0] c, input int j, input logic [7:0] b);
    int p;
    p = int'(c[15:2]);
    if (p != 0) begin
      if (j == p)      return c[31:24];
      if (j == p + 1)  return c[23:16];
      if (j == 24)     return c[47:40];
      if (j == 25)     return c[39:32];
    end
    return b;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Queue the expected output of one frame, then push its control word and bytes.
  task automatic applyStimulus(input logic [47:0] ctl, input int len, input int seed, input int stop_at);
    int outlen;
    int n;
    logic [7:0] b;
    if (!(ctl[1] || ctl[0])) begin
      outlen = (len < 60) ? 60 : len;
      for (int j = 0; j < outlen; j++) begin
        b = (j < len) ? din(j, seed) : 8'h00;
        exp_q.push_back({(j == outlen - 1), expByte(ctl, j, b)});
      end
    end
    ctl_if.tdata  = ctl;
    ctl_if.tvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!ctl_if.tready && n < 1000);
    if (!ctl_if.tready) checkOutput("ctl_accept", 32'(ctl_if.tready), 32'd1);
    @(posedge clk); #1;
    ctl_if.tvalid = 1'b0;
    for (int i = 0; i < stop_at; i++) begin
      frame_if.tdata  = din(i, seed);
      frame_if.tlast  = (i == len - 1);
      frame_if.tvalid = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!frame_if.tready && n < 1000);
      if (!frame_if.tready) begin
        checkOutput("frame_accept", 32'(frame_if.tready), 32'd1);
        break;
      end
      @(posedge clk); #1;
    end
    frame_if.tvalid = 1'b0;
    frame_if.tlast  = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin @(posedge clk); n++; end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain: %0d bytes still pending, expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // MAC-side ready: always 1, or a coin flip each cycle while rand_ready is set.
  initial begin
    m_if.tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_if.tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: scoreboard pop on each output handshake, plus hold checks while stalled.
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 1'b0;
      pos     = 0;
    end else begin
      if (stalled) begin
        checkOutput("stall_valid", 32'(m_if.tvalid), 32'd1);
        checkOutput("stall_data", 32'({m_if.tlast, m_if.tdata}), 32'(st_word));
      end
      if (m_if.tvalid && m_if.tready) begin
        if (pos < 256) cap[pos] = m_if.tdata;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_byte: got 0x%0h last=%0d, expected no output", m_if.tdata, m_if.tlast);
        end else begin
          exp_word = exp_q.pop_front();
          checkOutput($sformatf("byte[%0d]", pos), 32'({m_if.tlast, m_if.tdata}), 32'(exp_word));
        end
        pos = m_if.tlast ? 0 : pos + 1;
      end
      stalled = m_if.tvalid && !m_if.tready;
      st_word = {m_if.tlast, m_if.tdata};
    end
  end

  // Byte counter for the bad-FCS-forwarding instance.
  always @(negedge clk) begin
    if (rst_n && f_m.tvalid && f_m.tready) begin
      if (f_cnt == 0) f_b0 = f_m.tdata;
      if (f_m.tlast) f_last = f_cnt;
      f_cnt++;
    end
  end

  initial begin
    int n;
    rst_n = 1'b0;
    frame_if.tdata = '0; frame_if.tlast = 1'b0; frame_if.tvalid = 1'b0;
    ctl_if.tdata = '0; ctl_if.tlast = 1'b0; ctl_if.tvalid = 1'b0;
    f_frame.tdata = '0; f_frame.tlast = 1'b0; f_frame.tvalid = 1'b0;
    f_ctl.tdata = '0; f_ctl.tlast = 1'b0; f_ctl.tvalid = 1'b0;
    f_m.tready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_m_tvalid", 32'(m_if.tvalid), 32'd0);
    checkOutput("rst_m_tlast", 32'(m_if.tlast), 32'd0);
    checkOutput("rst_m_tdata", 32'(m_if.tdata), 32'd0);
    checkOutput("rst_frame_tready", 32'(frame_if.tready), 32'd0);
    checkOutput("rst_ctl_tready", 32'(ctl_if.tready), 32'd0);
    checkOutput("rst_frames_sent", frames_sent, 32'd0);
    checkOutput("rst_frames_dropped", frames_dropped, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    $display("[TB] 64-byte plain frame");
    applyStimulus(48'h0, 64, 1, 64);
    waitDrain();
    checkOutput("t1_frames_sent", frames_sent, 32'd1);

    $display("[TB] 80-byte frame with checksum patches");
    applyStimulus({16'h1234, 16'hABCD, 14'd40, 2'b00}, 80, 2, 80);
    waitDrain();
    checkOutput("t2_ip_hi", 32'(cap[24]), 32'h12);
    checkOutput("t2_ip_lo", 32'(cap[25]), 32'h34);
    checkOutput("t2_l4_hi", 32'(cap[40]), 32'hAB);
    checkOutput("t2_l4_lo", 32'(cap[41]), 32'hCD);
    checkOutput("t2_byte23", 32'(cap[23]), 32'h2D);
    checkOutput("t2_byte42", 32'(cap[42]), 32'h24);

    $display("[TB] 42-byte runt padded to 60");
    applyStimulus(48'h0, 42, 3, 42);
    waitDrain();
    checkOutput("t3_byte41", 32'(cap[41]), 32'h18);
    checkOutput("t3_pad42", 32'(cap[42]), 32'h00);
    checkOutput("t3_pad59", 32'(cap[59]), 32'h00);

    $display("[TB] overflow marker then good frame");
    applyStimulus(48'h2, 10, 4, 10);
    checkOutput("t4_frames_dropped", frames_dropped, 32'd1);
    applyStimulus(48'h0, 64, 5, 64);
    waitDrain();

    $display("[TB] bad FCS on discarding instance");
    applyStimulus(48'h1, 20, 6, 20);
    checkOutput("t5_frames_dropped", frames_dropped, 32'd2);

    $display("[TB] patches inside padding");
    applyStimulus({16'hBEEF, 16'hC3D4, 14'd50, 2'b00}, 10, 10, 10);
    waitDrain();
    checkOutput("pad_byte9", 32'(cap[9]), 32'h7F);
    checkOutput("pad_byte10", 32'(cap[10]), 32'h00);
    checkOutput("pad_ip_hi", 32'(cap[24]), 32'hBE);
    checkOutput("pad_ip_lo", 32'(cap[25]), 32'hEF);
    checkOutput("pad_l4_hi", 32'(cap[50]), 32'hC3);
    checkOutput("pad_l4_lo", 32'(cap[51]), 32'hD4);

    $display("[TB] length boundaries 1, 59, 60");
    applyStimulus(48'h0, 1, 11, 1);
    applyStimulus(48'h0, 59, 12, 59);
    applyStimulus(48'h0, 60, 13, 60);
    waitDrain();

    $display("[TB] 100-byte frame with random MAC ready");
    rand_ready = 1'b1;
    applyStimulus({16'h0102, 16'h0304, 14'd10, 2'b00}, 100, 7, 100);
    waitDrain();
    rand_ready = 1'b0;
    @(posedge clk); #1;
    checkOutput("frames_sent_total", frames_sent, 32'd9);
    checkOutput("frames_dropped_total", frames_dropped, 32'd2);

    $display("[TB] bad FCS on forwarding instance");
    f_ctl.tdata  = 48'h1;
    f_ctl.tvalid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!f_ctl.tready && n < 100);
    checkOutput("fwd_ctl_accept", 32'(f_ctl.tready), 32'd1);
    @(posedge clk); #1;
    f_ctl.tvalid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      f_frame.tdata  = din(i, 5);
      f_frame.tlast  = (i == 19);
      f_frame.tvalid = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (!f_frame.tready && n < 100);
      @(posedge clk); #1;
    end
    f_frame.tvalid = 1'b0;
    f_frame.tlast  = 1'b0;
    repeat (70) @(posedge clk);
    @(negedge clk);
    checkOutput("fwd_len", f_cnt, 32'd60);
    checkOutput("fwd_last_at", f_last, 32'd59);
    checkOutput("fwd_byte0", 32'(f_b0), 32'h05);
    checkOutput("fwd_frames_sent", fwd_sent, 32'd1);
    checkOutput("fwd_frames_dropped", fwd_dropped, 32'd0);
    @(posedge clk); #1;

    $display("[TB] reset in the middle of a frame");
    applyStimulus(48'h0, 100, 8, 30);
    frame_if.tdata  = din(30, 8);
    frame_if.tvalid = 1'b1;
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    checkOutput("mid_rst_m_tvalid", 32'(m_if.tvalid), 32'd0);
    checkOutput("mid_rst_m_tlast", 32'(m_if.tlast), 32'd0);
    checkOutput("mid_rst_m_tdata", 32'(m_if.tdata), 32'd0);
    checkOutput("mid_rst_frame_tready", 32'(frame_if.tready), 32'd0);
    checkOutput("mid_rst_ctl_tready", 32'(ctl_if.tready), 32'd0);
    checkOutput("mid_rst_frames_sent", frames_sent, 32'd0);
    @(posedge clk); #1;
    frame_if.tvalid = 1'b0;
    rst_n = 1'b1;
    applyStimulus(48'h0, 64, 9, 64);
    waitDrain();
    checkOutput("post_rst_frames_sent", frames_sent, 32'd1);
    checkOutput("post_rst_frames_dropped", frames_dropped, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/eth_frame_loop_tx.md
Name: eth_frame_loop_tx

Overview:
- Transmit-side consumer of the loop FIFO's frame and control streams, in the TX clock domain.
- Pops one 48-bit control word per frame, then either forwards or discards the frame bytes.
- On forwarded frames it patches the L4 and IP checksum bytes and zero-pads runts to the minimum size.
- Output is a byte AXI-Stream to the TX MAC, which appends the FCS.

Parameters:
C_MIN_FRAME_SIZE, 60, minimum emitted length in bytes (excluding FCS); shorter frames are zero-padded.
C_FORWARD_BAD_FCS, 0, 1 = forward frames whose FCS_INVALID bit is set; 0 = discard them.
C_IP_CSUM_OFFSET, 24, byte offset of the high byte of the IPv4 header checksum.

Ports:
clk  in  1  TX clock
rst_n  in  1  synchronous active-low reset
s_axis_frame_tdata  in  8  frame byte
s_axis_frame_tlast  in  1  last frame byte
s_axis_frame_tvalid  in  1  frame byte valid
s_axis_frame_tready  out  1  frame byte accept
s_axis_ctl_tdata  in  48  {IP_CSUM[47:32], CSUM_VAL[31:16], CSUM_POS[15:2], DROP_FRAME[1], FCS_INVALID[0]}
s_axis_ctl_tvalid  in  1  control word valid
s_axis_ctl_tready  out  1  control word accept
m_axis_tdata  out  8  byte to MAC
m_axis_tlast  out  1  last byte to MAC
m_axis_tvalid  out  1  byte valid to MAC
m_axis_tready  in  1  MAC accept
frames_sent  out  32  count of frames completed on m_axis
frames_dropped  out  32  count of frames discarded

Behaviour:
- Interface: reset rst_n, synchronous, active-low; clock clk.
- Reset state: ST_IDLE. All tready/tvalid/tlast outputs 0. m_axis_tdata 0. Both counters 0. Byte counter 0.
- A reset mid-frame abandons the frame. The upstream FIFO is reset in the same domain.
- ST_IDLE:
  - s_axis_ctl_tready=1, s_axis_frame_tready=0.
  - On ctl handshake, latch the control word into ctl_q and clear the byte counter idx.
  - Discard condition: DROP_FRAME=1, or (FCS_INVALID=1 and C_FORWARD_BAD_FCS=0).
  - If the discard condition holds -> ST_DISCARD, else -> ST_FORWARD.
  - Control word 2'b10 (overflow marker) therefore always discards.
- ST_FORWARD:
  - Combinational pass-through: m_axis_tvalid=s_axis_frame_tvalid, s_axis_frame_tready=m_axis_tready. Zero-cycle latency.
  - m_axis_tdata substitution by idx (first match wins):
    - idx=CSUM_POS, with CSUM_POS≠0: CSUM_VAL[15:8].
    - idx=CSUM_POS+1, with CSUM_POS≠0: CSUM_VAL[7:0].
    - idx=C_IP_CSUM_OFFSET, with CSUM_POS≠0: IP_CSUM[15:8].
    - idx=C_IP_CSUM_OFFSET+1, with CSUM_POS≠0: IP_CSUM[7:0].
    - Otherwise: input byte.
  - CSUM_POS=0 means no patching at all.
  - idx increments on each output handshake and saturates at 16'hFFFF. Patches never apply past the end of the frame.
  - On a handshake with tlast:
    - If idx ≥ C_MIN_FRAME_SIZE-1: m_axis_tlast=1, increment frames_sent, go to ST_IDLE.
    - Else: m_axis_tlast=0, go to ST_PAD.
- ST_PAD:
  - s_axis_frame_tready=0, m_axis_tvalid=1, data 0x00.
  - Patch rules still apply, so patch offsets inside the padding are written.
  - m_axis_tlast=1 when idx=C_MIN_FRAME_SIZE-1. On that handshake, increment frames_sent and go to ST_IDLE.
- ST_DISCARD:
  - s_axis_frame_tready=1, m_axis_tvalid=0.
  - On a handshake with tlast, increment frames_dropped and go to ST_IDLE.
- m_axis_tvalid is never withdrawn before its handshake, and m_axis_tdata is stable while stalled. Both follow from pass-through of a compliant FIFO source and the constant pad data.
- Counters wrap modulo 2^32.
- A ctl word is never accepted while a frame is in progress. At most one ctl pop per frame.
- Frame bytes arriving before their ctl word stall (tready=0). A ctl word waiting for frame bytes holds the FSM in FORWARD/DISCARD.
- A 1-byte frame (tlast on idx 0) is handled normally: padded, or discarded.

Test Plan:
- 64-byte frame, ctl=0 -> 64 bytes out unmodified, tlast on byte 63, frames_sent=1.
- 80-byte frame, CSUM_POS=40, CSUM_VAL=16'hABCD, IP_CSUM=16'h1234 -> out[24]=12, out[25]=34, out[40]=AB, out[41]=CD, other bytes unchanged, length 80.
- 42-byte frame, ctl=0 -> 60 bytes out; bytes 42..59 = 00; tlast on byte 59.
- ctl=2'b10 (overflow) with a 10-byte frame, then a 64-byte good frame -> first frame consumed with no m_axis output, frames_dropped=1; second frame forwarded intact.
- FCS_INVALID=1 with C_FORWARD_BAD_FCS=0 -> dropped; with C_FORWARD_BAD_FCS=1 -> forwarded.
- Random m_axis_tready (50%) during a 100-byte frame -> byte sequence identical to full-rate run; no tvalid drop or data change while stalled; reset asserted mid-frame -> all outputs 0 next cycle, FSM in IDLE.
